// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipeline.
// Owns the fetch address and runs a single-outstanding request/ready handshake
// to instruction memory. It also drives the IF/ID register that decode reads.
// A one-entry buffer catches a fetch that completes while IF/ID is stalled.
// A wrong-path request still in flight at redirect time is drained, and its
// response is discarded.
//
// state | meaning
// FETCH | request at fa outstanding; response loads IF/ID (or buffer when stalled)
// HOLD  | buffer holds a fetched instruction waiting for IF/ID to accept it; no request
// DRAIN | finishing a wrong-path request; response dropped, then resume at redirect target
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        ifid_valid,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_instr
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] fa_q, fa_n;
    logic [15:0] tgt_q, tgt_n;
    logic [15:0] buf_q, buf_n;
    logic [15:0] buf_pc_q, buf_pc_n;
    logic        valid_q, valid_n;
    logic [15:0] pc_q, pc_n;
    logic [15:0] instr_q, instr_n;
    logic        handshake;

    // Request is live in FETCH and DRAIN only, and never while reset is held.
    always_comb begin
        imem_req  = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && !rst;
        imem_addr = fa_q;
        handshake = imem_req && imem_ready;
    end

    // Next-state, fetch address, buffer and IF/ID register updates.
    always_comb begin
        state_n  = state_q;
        fa_n     = fa_q;
        tgt_n    = tgt_q;
        buf_n    = buf_q;
        buf_pc_n = buf_pc_q;
        valid_n  = valid_q;
        pc_n     = pc_q;
        instr_n  = instr_q;

        unique case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = 16'h0000;
                    instr_n = NOP_INSTR;
                    if (handshake) begin
                        fa_n = redirect_pc;
                    end else begin
                        // The request at fa is already in flight, so fa must stay put.
                        tgt_n   = redirect_pc;
                        state_n = S_DRAIN;
                    end
                end else if (handshake) begin
                    if (ifid_write) begin
                        valid_n = 1'b1;
                        pc_n    = fa_q;
                        instr_n = imem_rdata;
                        if (pc_write) begin
                            fa_n = fa_q + 16'd1;
                        end
                    end else begin
                        buf_n    = imem_rdata;
                        buf_pc_n = fa_q;
                        state_n  = S_HOLD;
                    end
                end else if (ifid_write) begin
                    valid_n = 1'b0;
                    pc_n    = 16'h0000;
                    instr_n = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    fa_n    = redirect_pc;
                    valid_n = 1'b0;
                    pc_n    = 16'h0000;
                    instr_n = NOP_INSTR;
                    state_n = S_FETCH;
                end else if (ifid_write) begin
                    valid_n = 1'b1;
                    pc_n    = buf_pc_q;
                    instr_n = buf_q;
                    if (pc_write) begin
                        fa_n = fa_q + 16'd1;
                    end
                    state_n = S_FETCH;
                end
            end
            S_DRAIN: begin
                valid_n = 1'b0;
                pc_n    = 16'h0000;
                instr_n = NOP_INSTR;
                if (redirect) begin
                    tgt_n = redirect_pc;
                end
                if (handshake) begin
                    // A redirect arriving in the same cycle is newer than tgt.
                    fa_n    = redirect ? redirect_pc : tgt_q;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            fa_q     <= RESET_PC;
            tgt_q    <= 16'h0000;
            buf_q    <= NOP_INSTR;
            buf_pc_q <= 16'h0000;
            valid_q  <= 1'b0;
            pc_q     <= 16'h0000;
            instr_q  <= NOP_INSTR;
        end else begin
            state_q  <= state_n;
            fa_q     <= fa_n;
            tgt_q    <= tgt_n;
            buf_q    <= buf_n;
            buf_pc_q <= buf_pc_n;
            valid_q  <= valid_n;
            pc_q     <= pc_n;
            instr_q  <= instr_n;
        end
    end

    // IF/ID register drives decode directly.
    always_comb begin
        ifid_valid = valid_q;
        ifid_pc    = pc_q;
        ifid_instr = instr_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// A scoreboard holds the expected fetch addresses and IF/ID loads.
// A monitor pops and compares them as the DUT presents them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_ifid_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    // Memory model: data presented with ready, garbage otherwise.
    assign imem_rdata = imem_ready ? instr_of(imem_addr) : 16'hDEAD;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_fetch(input logic [15:0] a, input bit loads);
        exp_addr_q.push_back(a);
        if (loads) exp_ifid_q.push_back({a, instr_of(a)});
    endtask

    task automatic cyc(input logic pw, input logic iw, input logic rdy,
                       input logic rd, input logic [15:0] rpc);
        pc_write    = pw;
        ifid_write  = iw;
        imem_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshake addresses are checked mid-cycle, and IF/ID loads after each edge.
    initial begin : monitor
        logic        w_at_edge;
        logic        r_at_edge;
        logic [15:0] ea;
        logic [31:0] ei;
        forever begin
            @(posedge clk);
            w_at_edge = ifid_write;
            r_at_edge = rst;
            if (!rst && ifid_write && !pc_write) begin
                n_bad++;
                $display("FAIL illegal_stall_combo: pc_write=0 with ifid_write=1");
            end
            @(negedge clk);
            if (!r_at_edge && w_at_edge && ifid_valid) begin
                if (exp_ifid_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ifid_unexpected: got pc %h instr %h expected none", ifid_pc, ifid_instr);
                end else begin
                    ei = exp_ifid_q.pop_front();
                    check("ifid_load", {ifid_pc, ifid_instr}, ei);
                end
            end
            if (imem_req && imem_ready) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got addr %h expected none", imem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("req_addr", {16'h0, imem_addr}, {16'h0, ea});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; imem_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_valid", {31'h0, ifid_valid}, 32'h0);
        check("rst_pc",    {16'h0, ifid_pc},    32'h0);
        check("rst_instr", {16'h0, ifid_instr}, 32'h0);
        rst = 1'b0;
        #1;
        check("first_req",  {31'h0, imem_req},  32'h1);
        check("first_addr", {16'h0, imem_addr}, 32'h0);

        // Straight-line fetch from address 0.
        for (int i = 0; i < 5; i++) begin
            exp_fetch(16'(i), 1'b1);
            cyc(1, 1, 1, 0, 16'h0);
            if (i == 0) check("t1_valid", {31'h0, ifid_valid}, 32'h1);
        end

        // Instruction 5 returns while the pipeline is stalled for one cycle.
        exp_fetch(16'h0005, 1'b0);
        cyc(0, 0, 1, 0, 16'h0);
        check("t2_hold_req", {31'h0, imem_req}, 32'h0);
        check("t2_held_pc",  {16'h0, ifid_pc},  32'h4);
        exp_ifid_q.push_back({16'h0005, instr_of(16'h0005)});
        cyc(1, 1, 1, 0, 16'h0);
        check("t2_pc5",   {16'h0, ifid_pc},   32'h5);
        check("t2_addr6", {16'h0, imem_addr}, 32'h6);

        // Memory is slow on address 8: three bubbles, then 8 arrives.
        exp_fetch(16'h0006, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        exp_fetch(16'h0007, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 16'h0);
            check("t3_addr_stable", {16'h0, imem_addr}, 32'h8);
            check("t3_bubble",      {31'h0, ifid_valid}, 32'h0);
        end
        exp_fetch(16'h0008, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        check("t3_pc8", {16'h0, ifid_pc}, 32'h8);

        // Redirect while address 9 is outstanding: drain, then fetch at 0x0040.
        cyc(1, 1, 0, 1, 16'h0040);
        check("t4_drain_addr",  {16'h0, imem_addr},  32'h9);
        check("t4_drain_req",   {31'h0, imem_req},   32'h1);
        check("t4_drain_valid", {31'h0, ifid_valid}, 32'h0);
        cyc(1, 1, 0, 0, 16'h0);
        check("t4_drain_addr2", {16'h0, imem_addr}, 32'h9);
        exp_fetch(16'h0009, 1'b0);
        cyc(1, 1, 1, 0, 16'h0);
        check("t4_target",    {16'h0, imem_addr},  32'h40);
        check("t4_dropped",   {31'h0, ifid_valid}, 32'h0);
        exp_fetch(16'h0040, 1'b1); cyc(1, 1, 1, 0, 16'h0);

        // Redirect while holding a buffered instruction: buffer is discarded.
        exp_fetch(16'h0041, 1'b0);
        cyc(0, 0, 1, 0, 16'h0);
        check("t5_hold_req", {31'h0, imem_req}, 32'h0);
        cyc(1, 1, 1, 1, 16'h0100);
        check("t5_flush", {31'h0, ifid_valid}, 32'h0);
        check("t5_addr",  {16'h0, imem_addr},  32'h100);
        exp_fetch(16'h0100, 1'b1); cyc(1, 1, 1, 0, 16'h0);

        // Redirect in the same cycle as a handshake: data dropped, jump near the top.
        exp_fetch(16'h0101, 1'b0);
        cyc(1, 1, 1, 1, 16'hFFFE);
        check("t6_redir_hs_valid", {31'h0, ifid_valid}, 32'h0);
        check("t6_redir_hs_addr",  {16'h0, imem_addr},  32'hFFFE);
        exp_fetch(16'hFFFE, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        exp_fetch(16'hFFFF, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        check("t6_wrap", {16'h0, imem_addr}, 32'h0);
        exp_fetch(16'h0000, 1'b1); cyc(1, 1, 1, 0, 16'h0);

        // Repeated redirects during a drain: the latest target wins.
        cyc(1, 1, 0, 1, 16'h0200);
        check("t7_drain_addr", {16'h0, imem_addr}, 32'h1);
        cyc(1, 1, 0, 1, 16'h0300);
        exp_fetch(16'h0001, 1'b0);
        cyc(1, 1, 1, 1, 16'h0400);
        check("t7_latest", {16'h0, imem_addr}, 32'h400);

        // Reset asserted mid-drain returns to the reset address.
        cyc(1, 1, 0, 1, 16'h0500);
        check("t8_drain_addr", {16'h0, imem_addr}, 32'h400);
        rst = 1'b1; imem_ready = 1'b1; redirect = 1'b0;
        #1;
        check("t8_rst_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t8_req",   {31'h0, imem_req},   32'h1);
        check("t8_addr",  {16'h0, imem_addr},  32'h0);
        check("t8_valid", {31'h0, ifid_valid}, 32'h0);
        exp_fetch(16'h0000, 1'b1); cyc(1, 1, 1, 0, 16'h0);
        check("t8_pc0", {16'h0, ifid_pc}, 32'h0);

        repeat (2) cyc(1, 1, 0, 0, 16'h0);
        check("addr_q_drained", exp_addr_q.size(), 32'h0);
        check("ifid_q_drained", exp_ifid_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
